fft_shift_buf: RTL and testbench
================================

Name: fft_shift_buf

Overview:
- Delay/pairing buffer that sits directly upstream of the radix-2 add/sub butterfly stage.
- Captures the first half of each FFT block (DEPTH input vectors of DATA_WIDTH parallel complex lanes).
- Replays the stored half in lockstep with the second half, driving the butterfly's "current" and "shift-register" operand ports aligned on the same cycle.
- Flags pair validity and block boundaries for the downstream stage.

Parameters:
- WIDTH, 9, signed bit width of each real/imag component.
- DATA_WIDTH, 16, number of parallel lanes per vector.
- DEPTH, 4, vectors per half-block; power of 2, >=2; block length = 2*DEPTH vectors.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  synchronous active-low reset.
- clr  in  1  synchronous block restart; aborts the current block.
- din_valid  in  1  input vector valid this cycle.
- din_re  in  signed WIDTH x [0:DATA_WIDTH-1]  input real lanes.
- din_im  in  signed WIDTH x [0:DATA_WIDTH-1]  input imag lanes.
- dout_valid  out  1  aligned pair valid.
- dout_re  out  signed WIDTH x [0:DATA_WIDTH-1]  second-half sample, real; feeds butterfly din_re.
- dout_im  out  signed WIDTH x [0:DATA_WIDTH-1]  second-half sample, imag.
- dout_shift_reg_re  out  signed WIDTH x [0:DATA_WIDTH-1]  stored first-half sample, real; feeds butterfly din_shift_reg_re.
- dout_shift_reg_im  out  signed WIDTH x [0:DATA_WIDTH-1]  stored first-half sample, imag.
- dout_first  out  1  high with the first pair of a block.
- dout_last  out  1  high with the last pair of a block.
- busy  out  1  high when a block is partially received.

Behaviour:
- All registers update on posedge clk. rstn low at an edge: all outputs 0, state FILL, counters 0.
- Buffer memory contents are not reset and are don't-care until rewritten.
- State machine has two states:
  - FILL: each din_valid writes din_re/din_im (all lanes) into buffer[cnt] and increments cnt. When cnt==DEPTH-1 and din_valid, set cnt=0 and go to PAIR. No output is produced in FILL.
  - PAIR: each din_valid registers the pair: dout_re/im <= din, dout_shift_reg_re/im <= buffer[cnt], dout_valid <= 1, then cnt++. dout_first <= (cnt==0). dout_last <= (cnt==DEPTH-1). On cnt==DEPTH-1, set cnt=0 and go to FILL.
- Latency: exactly 1 cycle from the second-half din_valid to dout_valid.
- Cycles without din_valid are bubbles:
  - state and cnt hold;
  - dout_valid, dout_first and dout_last are 0 the next cycle;
  - dout data outputs hold their last values.
- busy = (state==PAIR) or (cnt!=0), registered.
- clr high: state FILL, cnt 0, dout_valid/first/last 0 next cycle, busy 0. The din presented on that cycle is dropped even if din_valid is high. Buffer contents are untouched.
- rstn has priority over clr; clr has priority over din_valid.
- Back-to-back blocks are supported with no gap cycles: the transition from the last PAIR cycle to FILL with valid input on the very next cycle is lossless.
- Buffer read and write do not collide. In PAIR, buffer[cnt] is read before any FILL rewrites it, because writes occur only in FILL.
- No arithmetic and no width growth: data is passed bit-exact, sign preserved.
- Lanes are independent. Lane i of the output always comes from lane i of the input.

Test Plan:
- Common stimulus for these scenarios: DEPTH=4; vector k (0..7) has lane i re=k*16+i, im=-(k*16+i).
- Basic block: reset, then 8 consecutive valid vectors.
  - No dout_valid during the first 4 cycles.
  - Cycles 5-8 give dout_valid=1 with dout_re lane i = (k+4)*16+i and dout_shift_reg_re lane i = k*16+i for k=0..3.
  - Imag parts are the negatives of the real parts.
  - dout_first on k=0, dout_last on k=3.
- Bubbles: same stream with din_valid low on alternate cycles. Pairing is identical, dout_valid toggles, and data outputs hold during gaps.
- Back-to-back: 3 blocks with no gaps.
  - 12 valid pairs total, each block paired only with its own first half.
  - dout_first/dout_last are asserted once per block.
- clr mid-PAIR: assert clr with the 2nd second-half vector.
  - dout_valid drops the next cycle, busy=0.
  - A following full 8-vector block pairs correctly, with no stale data.
- Reset mid-FILL: rstn low after 2 vectors.
  - All outputs read 0 the next cycle.
  - Re-feeding a full block produces the basic-block result.
- Sign extremes: lane values -256 and 255. They appear bit-exact on the outputs with no sign corruption.

Source files
------------

// File: rtl/fft_shift_buf.sv
// rtl/fft_shift_buf.sv - first-half capture and replay buffer pairing operands for a radix-2 butterfly
module fft_shift_buf #(
    parameter int WIDTH      = 9,
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    clr,
    input  logic                    din_valid,
    input  logic signed [WIDTH-1:0] din_re            [0:DATA_WIDTH-1],
    input  logic signed [WIDTH-1:0] din_im            [0:DATA_WIDTH-1],
    output logic                    dout_valid,
    output logic signed [WIDTH-1:0] dout_re           [0:DATA_WIDTH-1],
    output logic signed [WIDTH-1:0] dout_im           [0:DATA_WIDTH-1],
    output logic signed [WIDTH-1:0] dout_shift_reg_re [0:DATA_WIDTH-1],
    output logic signed [WIDTH-1:0] dout_shift_reg_im [0:DATA_WIDTH-1],
    output logic                    dout_first,
    output logic                    dout_last,
    output logic                    busy
);

    localparam int CW = $clog2(DEPTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);

    typedef enum logic {FILL = 1'b0, PAIR = 1'b1} state_t;

    state_t        state;
    logic [CW-1:0] cnt;

    // First-half storage; never reset, every entry is rewritten before it is read
    logic signed [WIDTH-1:0] buf_re [0:DEPTH-1][0:DATA_WIDTH-1];
    logic signed [WIDTH-1:0] buf_im [0:DEPTH-1][0:DATA_WIDTH-1];

    // Capture first-half vectors; writes only happen in FILL so PAIR reads never collide
    always_ff @(posedge clk) begin
        if (rstn && !clr && din_valid && state == FILL) begin
            buf_re[cnt] <= din_re;
            buf_im[cnt] <= din_im;
        end
    end

    // Fill/pair sequencing with registered pair outputs and block flags
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= FILL;
            cnt        <= '0;
            dout_valid <= 1'b0;
            dout_first <= 1'b0;
            dout_last  <= 1'b0;
            busy       <= 1'b0;
            for (int i = 0; i < DATA_WIDTH; i++) begin
                dout_re[i]           <= '0;
                dout_im[i]           <= '0;
                dout_shift_reg_re[i] <= '0;
                dout_shift_reg_im[i] <= '0;
            end
        end else if (clr) begin
            state      <= FILL;
            cnt        <= '0;
            dout_valid <= 1'b0;
            dout_first <= 1'b0;
            dout_last  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            dout_valid <= 1'b0;
            dout_first <= 1'b0;
            dout_last  <= 1'b0;
            if (din_valid) begin
                case (state)
                    FILL: begin
                        // any accepted first-half vector leaves a block partially received
                        busy <= 1'b1;
                        if (cnt == CNT_LAST) begin
                            cnt   <= '0;
                            state <= PAIR;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    PAIR: begin
                        dout_re           <= din_re;
                        dout_im           <= din_im;
                        dout_shift_reg_re <= buf_re[cnt];
                        dout_shift_reg_im <= buf_im[cnt];
                        dout_valid        <= 1'b1;
                        dout_first        <= (cnt == '0);
                        dout_last         <= (cnt == CNT_LAST);
                        if (cnt == CNT_LAST) begin
                            cnt   <= '0;
                            state <= FILL;
                            busy  <= 1'b0;
                        end else begin
                            cnt  <= cnt + 1'b1;
                            busy <= 1'b1;
                        end
                    end
                    default: begin
                        state <= FILL;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fft_shift_buf.sv
// tb/tb_fft_shift_buf.sv - directed self-checking bench for fft_shift_buf
module tb_fft_shift_buf;

    localparam int W = 9;
    localparam int L = 16;
    localparam int D = 4;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic clr = 1'b0;
    logic din_valid = 1'b0;
    logic signed [W-1:0] din_re [0:L-1];
    logic signed [W-1:0] din_im [0:L-1];
    logic dout_valid, dout_first, dout_last, busy;
    logic signed [W-1:0] dout_re [0:L-1];
    logic signed [W-1:0] dout_im [0:L-1];
    logic signed [W-1:0] dout_shift_reg_re [0:L-1];
    logic signed [W-1:0] dout_shift_reg_im [0:L-1];

    logic signed [W-1:0] e_re  [0:L-1];
    logic signed [W-1:0] e_im  [0:L-1];
    logic signed [W-1:0] e_sre [0:L-1];
    logic signed [W-1:0] e_sim [0:L-1];

    int vectors = 0;
    int errs = 0;

    fft_shift_buf #(.WIDTH(W), .DATA_WIDTH(L), .DEPTH(D)) dut (
        .clk               (clk),
        .rstn              (rstn),
        .clr               (clr),
        .din_valid         (din_valid),
        .din_re            (din_re),
        .din_im            (din_im),
        .dout_valid        (dout_valid),
        .dout_re           (dout_re),
        .dout_im           (dout_im),
        .dout_shift_reg_re (dout_shift_reg_re),
        .dout_shift_reg_im (dout_shift_reg_im),
        .dout_first        (dout_first),
        .dout_last         (dout_last),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    function automatic logic signed [W-1:0] vr(input int n, input int i);
        return W'(n * 16 + i);
    endfunction

    function automatic logic signed [W-1:0] vi(input int n, input int i);
        return W'(-(n * 16 + i));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int n, input logic v);
        for (int i = 0; i < L; i++) begin
            din_re[i] = vr(n, i);
            din_im[i] = vi(n, i);
        end
        din_valid = v;
    endtask

    task automatic zero_exp();
        for (int i = 0; i < L; i++) begin
            e_re[i] = '0; e_im[i] = '0; e_sre[i] = '0; e_sim[i] = '0;
        end
    endtask

    task automatic set_exp(input int ncur, input int nsh);
        for (int i = 0; i < L; i++) begin
            e_re[i]  = vr(ncur, i);
            e_im[i]  = vi(ncur, i);
            e_sre[i] = vr(nsh, i);
            e_sim[i] = vi(nsh, i);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_ctl(input string tag, input logic v, input logic f, input logic l, input logic b);
        chk1({tag, " valid"}, dout_valid, v);
        chk1({tag, " first"}, dout_first, f);
        chk1({tag, " last"}, dout_last, l);
        chk1({tag, " busy"}, busy, b);
    endtask

    task automatic chk_data(input string tag);
        for (int i = 0; i < L; i++) begin
            vectors++;
            assert (dout_re[i] === e_re[i] && dout_im[i] === e_im[i] &&
                    dout_shift_reg_re[i] === e_sre[i] && dout_shift_reg_im[i] === e_sim[i]) else begin
                errs++;
                $error("FAIL %s lane %0d: got re=%0d im=%0d sre=%0d sim=%0d expected re=%0d im=%0d sre=%0d sim=%0d",
                       tag, i, dout_re[i], dout_im[i], dout_shift_reg_re[i], dout_shift_reg_im[i],
                       e_re[i], e_im[i], e_sre[i], e_sim[i]);
            end
        end
    endtask

    // Feeds vectors base..base+nvec-1 of a block, optionally with a bubble after each
    task automatic feed(input int base, input logic bubbles, input int nvec);
        string tag;
        for (int k = 0; k < nvec; k++) begin
            tag = $sformatf("blk%0d k%0d", base, k);
            drive(base + k, 1'b1);
            step();
            if (k >= D) begin
                set_exp(base + k, base + k - D);
                chk_ctl(tag, 1'b1, k == D, k == 2 * D - 1, k != 2 * D - 1);
            end else begin
                chk_ctl(tag, 1'b0, 1'b0, 1'b0, 1'b1);
            end
            chk_data(tag);
            if (bubbles) begin
                drive(99, 1'b0);
                step();
                chk_ctl({tag, " gap"}, 1'b0, 1'b0, 1'b0, k != 2 * D - 1);
                chk_data({tag, " gap"});
            end
        end
    endtask

    initial begin
        // reset state
        drive(0, 1'b0);
        rstn = 1'b0;
        step();
        zero_exp();
        chk_ctl("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        chk_data("reset");
        rstn = 1'b1;

        // basic block
        feed(0, 1'b0, 8);

        // bubbles on alternate cycles
        feed(0, 1'b1, 8);

        // three back-to-back blocks
        feed(0, 1'b0, 8);
        feed(8, 1'b0, 8);
        feed(16, 1'b0, 8);

        // clr with the second second-half vector
        feed(32, 1'b0, 5);
        drive(37, 1'b1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk_ctl("clr", 1'b0, 1'b0, 1'b0, 1'b0);
        chk_data("clr hold");
        feed(40, 1'b0, 8);

        // reset mid-fill
        feed(0, 1'b0, 2);
        drive(2, 1'b1);
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        zero_exp();
        chk_ctl("rst mid", 1'b0, 1'b0, 1'b0, 1'b0);
        chk_data("rst mid");
        feed(0, 1'b0, 8);

        // sign extremes
        for (int k = 0; k < 2 * D; k++) begin
            for (int i = 0; i < L; i++) begin
                din_re[i] = ((i % 2 == 1) ^ (k >= D)) ? 9'sd255 : -9'sd256;
                din_im[i] = ((i % 2 == 1) ^ (k >= D)) ? -9'sd256 : 9'sd255;
            end
            din_valid = 1'b1;
            step();
            if (k >= D) begin
                for (int i = 0; i < L; i++) begin
                    e_re[i]  = (i % 2 == 1) ? -9'sd256 : 9'sd255;
                    e_im[i]  = (i % 2 == 1) ? 9'sd255 : -9'sd256;
                    e_sre[i] = (i % 2 == 1) ? 9'sd255 : -9'sd256;
                    e_sim[i] = (i % 2 == 1) ? -9'sd256 : 9'sd255;
                end
                chk_ctl($sformatf("ext k%0d", k), 1'b1, k == D, k == 2 * D - 1, k != 2 * D - 1);
                chk_data($sformatf("ext k%0d", k));
            end
        end
        din_valid = 1'b0;
        step();
        chk_ctl("final idle", 1'b0, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
